// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : one memory port shared by fetch and load/store, with
//                    ls priority, fetch starvation guard, one-word fetch buffer
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ready,
  output logic                  if_valid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  output logic                  ls_ready,
  output logic                  ls_valid,
  output logic [DATA_WIDTH-1:0] ls_rdata,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic                  buf_valid_q, buf_valid_d;
  logic [ADDR_WIDTH-1:0] buf_tag_q, buf_tag_d;
  logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;
  logic [ADDR_WIDTH-1:0] if_tag_q, if_tag_d;
  logic [DATA_WIDTH-1:0] hit_data_q, hit_data_d;
  logic [3:0]            starve_q, starve_d;
  logic                  rd_if_q, rd_if_d;
  logic                  rd_if_hit_q, rd_if_hit_d;
  logic                  rd_ls_q, rd_ls_d;

  logic [ADDR_WIDTH-1:0] if_word, ls_word;
  logic                  run, if_hit, if_miss, fetch_forced;
  logic                  ls_grant, if_mem_grant, ls_wr_grant, hit_ok;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{if_addr[1:0], ls_addr[1:0]};

  always_comb begin
    run          = ~reset;
    if_word      = {if_addr[ADDR_WIDTH-1:2], 2'b00};
    ls_word      = {ls_addr[ADDR_WIDTH-1:2], 2'b00};
    if_hit       = if_req & buf_valid_q & (if_word == buf_tag_q);
    if_miss      = if_req & ~if_hit;
    fetch_forced = if_miss & (starve_q == STARVE_MAX);
    ls_grant     = ls_req & ~fetch_forced;
    if_mem_grant = if_miss & (fetch_forced | ~ls_req);
    ls_wr_grant  = ls_grant & ls_we;
    // A hit must not return buffer data that the same-cycle write makes stale
    hit_ok       = if_hit & ~(ls_wr_grant & (ls_word == buf_tag_q));

    if_ready = run & (hit_ok | if_mem_grant);
    ls_ready = run & ls_grant;

    mem_write_enable = 1'b0;
    mem_address      = '0;
    mem_data_in      = '0;
    if (run && if_mem_grant) begin
      mem_address = if_word;
    end else if (run && ls_grant) begin
      mem_address      = ls_word;
      mem_write_enable = ls_we;
      mem_data_in      = ls_we ? ls_wdata : '0;
    end

    if_valid = run & rd_if_q;
    if_rdata = '0;
    if (if_valid) if_rdata = rd_if_hit_q ? hit_data_q : mem_data_out;
    ls_valid = run & rd_ls_q;
    ls_rdata = ls_valid ? mem_data_out : '0;
  end

  always_comb begin
    rd_if_d     = if_ready;
    rd_if_hit_d = run & hit_ok;
    rd_ls_d     = ls_ready & ~ls_we;
    if_tag_d    = if_word;
    hit_data_d  = buf_data_q;

    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    if (rd_if_q && !rd_if_hit_q) begin
      buf_valid_d = 1'b1;
      buf_tag_d   = if_tag_q;
      buf_data_d  = mem_data_out;
    end
    // Invalidate after the fill so a same-word write also kills a fresh fill
    if (run && ls_wr_grant && (ls_word == buf_tag_d)) buf_valid_d = 1'b0;

    starve_d = 4'd0;
    if (if_req && !if_ready)
      starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
      if_tag_q    <= '0;
      hit_data_q  <= '0;
      starve_q    <= 4'd0;
      rd_if_q     <= 1'b0;
      rd_if_hit_q <= 1'b0;
      rd_ls_q     <= 1'b0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
      if_tag_q    <= if_tag_d;
      hit_data_q  <= hit_data_d;
      starve_q    <= starve_d;
      rd_if_q     <= rd_if_d;
      rd_if_hit_q <= rd_if_hit_d;
      rd_ls_q     <= rd_ls_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter : directed self-checking bench with a one-cycle ROM model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_ready, if_valid;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_ready, ls_valid;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic        mem_write_enable;
  logic [31:0] mem_address, mem_data_in;
  logic [31:0] mem_data_out = 32'h0;
  logic [31:0] rom [16];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ready(ls_ready), .ls_valid(ls_valid), .ls_rdata(ls_rdata),
    .mem_write_enable(mem_write_enable), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  initial for (int i = 0; i < 16; i++) rom[i] = 32'h0;

  always @(posedge clk) begin
    if (mem_write_enable) rom[mem_address[5:2]] <= mem_data_in;
    mem_data_out <= rom[mem_address[5:2]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; if_req = 1'b1; if_addr = 32'h08000010;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h08000010; ls_wdata = 32'hFFFFFFFF;
    tick(); tick(); #1;
    check("rst_if_ready", {31'b0, if_ready}, 32'd0);
    check("rst_ls_ready", {31'b0, ls_ready}, 32'd0);
    check("rst_mem_we", {31'b0, mem_write_enable}, 32'd0);
    check("rst_mem_addr", mem_address, 32'h0);
    check("rst_mem_din", mem_data_in, 32'h0);
    check("rst_if_valid", {31'b0, if_valid}, 32'd0);
    check("rst_ls_valid", {31'b0, ls_valid}, 32'd0);
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    tick();
    reset = 1'b0;

    // ls write then fetch miss of the same word
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h08000010; ls_wdata = 32'h67452301;
    #1;
    check("wr_ls_ready", {31'b0, ls_ready}, 32'd1);
    check("wr_mem_we", {31'b0, mem_write_enable}, 32'd1);
    check("wr_mem_addr", mem_address, 32'h08000010);
    check("wr_mem_din", mem_data_in, 32'h67452301);
    tick();
    ls_req = 1'b0; ls_we = 1'b0;
    if_req = 1'b1; if_addr = 32'h08000010;
    #1;
    check("wr_no_ls_valid", {31'b0, ls_valid}, 32'd0);
    check("miss_if_ready", {31'b0, if_ready}, 32'd1);
    check("miss_mem_we", {31'b0, mem_write_enable}, 32'd0);
    check("miss_mem_addr", mem_address, 32'h08000010);
    tick();
    if_req = 1'b0;
    check("miss_if_valid", {31'b0, if_valid}, 32'd1);
    check("miss_if_rdata", if_rdata, 32'h67452301);
    tick();

    // buffer hit on the other halfword
    if_req = 1'b1; if_addr = 32'h08000012;
    #1;
    check("hit_if_ready", {31'b0, if_ready}, 32'd1);
    check("hit_mem_we", {31'b0, mem_write_enable}, 32'd0);
    check("hit_mem_addr", mem_address, 32'h0);
    tick();
    if_req = 1'b0;
    check("hit_if_valid", {31'b0, if_valid}, 32'd1);
    check("hit_if_rdata", if_rdata, 32'h67452301);
    tick();

    // same-word write invalidates the buffer
    if_req = 1'b1; if_addr = 32'h08000012;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h08000010; ls_wdata = 32'hDDCCBBAA;
    #1;
    check("inv_ls_ready", {31'b0, ls_ready}, 32'd1);
    check("inv_if_refused", {31'b0, if_ready}, 32'd0);
    check("inv_mem_we", {31'b0, mem_write_enable}, 32'd1);
    tick();
    ls_req = 1'b0; ls_we = 1'b0;
    #1;
    check("inv_if_valid_none", {31'b0, if_valid}, 32'd0);
    check("inv_miss_ready", {31'b0, if_ready}, 32'd1);
    check("inv_miss_addr", mem_address, 32'h08000010);
    tick();
    if_req = 1'b0;
    check("inv_if_valid", {31'b0, if_valid}, 32'd1);
    check("inv_if_rdata", if_rdata, 32'hDDCCBBAA);
    tick();

    // preload 0x08000014, then starve fetch behind back-to-back ls reads
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h08000014; ls_wdata = 32'h11223344;
    tick();
    ls_we = 1'b0; ls_addr = 32'h08000010;
    if_req = 1'b1; if_addr = 32'h08000014;
    for (int c = 1; c <= 4; c++) begin
      #1;
      check($sformatf("stv_c%0d_ls_ready", c), {31'b0, ls_ready}, 32'd1);
      check($sformatf("stv_c%0d_if_ready", c), {31'b0, if_ready}, 32'd0);
      check($sformatf("stv_c%0d_mem_addr", c), mem_address, 32'h08000010);
      check($sformatf("stv_c%0d_ls_valid", c), {31'b0, ls_valid}, (c == 1) ? 32'd0 : 32'd1);
      if (c > 1) check($sformatf("stv_c%0d_ls_rdata", c), ls_rdata, 32'hDDCCBBAA);
      tick();
    end
    #1;
    check("stv_c5_if_ready", {31'b0, if_ready}, 32'd1);
    check("stv_c5_ls_ready", {31'b0, ls_ready}, 32'd0);
    check("stv_c5_mem_addr", mem_address, 32'h08000014);
    check("stv_c5_ls_valid", {31'b0, ls_valid}, 32'd1);
    tick();
    if_req = 1'b0;
    check("stv_c6_if_valid", {31'b0, if_valid}, 32'd1);
    check("stv_c6_if_rdata", if_rdata, 32'h11223344);
    check("stv_c6_ls_valid", {31'b0, ls_valid}, 32'd0);
    check("stv_starve_cleared", {28'b0, dut.starve_q}, 32'd0);
    ls_req = 1'b0;
    tick();

    // misaligned ls read
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h08000013;
    #1;
    check("mis_ls_ready", {31'b0, ls_ready}, 32'd1);
    check("mis_mem_addr", mem_address, 32'h08000010);
    tick();
    ls_req = 1'b0;
    check("mis_ls_valid", {31'b0, ls_valid}, 32'd1);
    check("mis_ls_rdata", ls_rdata, 32'hDDCCBBAA);
    check("mis_no_if_valid", {31'b0, if_valid}, 32'd0);
    tick();

    // reset while a fetch miss is outstanding
    if_req = 1'b1; if_addr = 32'h08000018;
    #1;
    check("rmr_if_ready", {31'b0, if_ready}, 32'd1);
    tick();
    reset = 1'b1;
    #1;
    check("rmr_if_valid", {31'b0, if_valid}, 32'd0);
    check("rmr_if_rdata", if_rdata, 32'h0);
    check("rmr_if_ready_rst", {31'b0, if_ready}, 32'd0);
    check("rmr_mem_addr", mem_address, 32'h0);
    tick();
    check("rmr_buf_valid", {31'b0, dut.buf_valid_q}, 32'd0);
    reset = 1'b0; if_req = 1'b0;
    tick();
    check("rmr_post_if_valid", {31'b0, if_valid}, 32'd0);

    // buffered word 0x08000014 must miss after reset
    if_req = 1'b1; if_addr = 32'h08000016;
    #1;
    check("post_rst_miss_addr", mem_address, 32'h08000014);
    tick();
    if_req = 1'b0;
    check("post_rst_rdata", if_rdata, 32'h11223344);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port memory arbiter between the instruction fetch path and the load/store path. Both share the one synchronous program memory (`rom`: 32-bit `address`, `data_in`, `data_out`, `write_enable`, one-cycle read latency). The arbiter grants one memory access per cycle with load/store priority and a starvation guard for fetch. It also keeps a one-word fetch buffer, so the second Thumb halfword of a word is served without a memory access. It sits between Fetch, the load/store unit and `rom`.

## Interface
- ADDR_WIDTH, 32, address width, both requesters and memory
- DATA_WIDTH, 32, memory word width
- STARVE_LIMIT, 4, number of consecutive cycles fetch may be refused a memory grant while requesting; range 1..15
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request
- if_addr  in  ADDR_WIDTH  fetch byte address (halfword-aligned)
- if_ready  out  1  fetch request accepted this cycle
- if_valid  out  1  fetch read data valid
- if_rdata  out  DATA_WIDTH  full word containing if_addr
- ls_req  in  1  load/store request
- ls_we  in  1  1 = write, 0 = read
- ls_addr  in  ADDR_WIDTH  load/store byte address
- ls_wdata  in  DATA_WIDTH  write data
- ls_ready  out  1  load/store request accepted this cycle
- ls_valid  out  1  load read data valid (reads only)
- ls_rdata  out  DATA_WIDTH  load read data
- mem_write_enable  out  1  to rom write_enable
- mem_address  out  ADDR_WIDTH  to rom address, always word-aligned
- mem_data_in  out  DATA_WIDTH  to rom data_in
- mem_data_out  in  DATA_WIDTH  from rom data_out, valid the cycle after address

## Operation
- Word address = addr with bits [1:0] forced to 0, for both requesters. Halfword selection is done by Fetch, not here.
- Fetch buffer state: buf_valid, buf_tag (word address), buf_data. Fetch hit = if_req & buf_valid & word(if_addr)==buf_tag.
- **Per-cycle arbitration (combinational, cycle N):**
  - **Fetch hit:** if_ready=1 with no memory use. The exception is when ls is granted a write to the same word that cycle; the hit is then refused.
  - **Memory owner:**
    - Fetch owns memory if starve_cnt==STARVE_LIMIT and the access is a fetch miss.
    - Otherwise ls owns memory if ls_req is high.
    - Otherwise fetch owns memory on a miss.
    - Otherwise memory is idle.
  - **Idle memory:** mem_write_enable=0, mem_address=0, mem_data_in=0.
  - **ls write granted:** mem_write_enable=1, mem_data_in=ls_wdata. If the word matches buf_tag, buf_valid is cleared at the end of N.
- **starve_cnt (4 bits):**
  - Increments when if_req=1 and if_ready=0, saturating at STARVE_LIMIT.
  - Cleared when if_ready=1 or if_req=0.
- **Response (cycle N+1):**
  - Registered flags rd_if and rd_ls record which read was issued in N.
  - if_valid=1 with if_rdata = mem_data_out on a miss, or buf_data on a hit.
  - ls_valid=1 with ls_rdata = mem_data_out, for ls reads only.
  - Writes complete on ls_ready and never produce ls_valid.
- On a fetch miss response in N+1: buf_data<=mem_data_out, buf_tag<=word address, buf_valid<=1.
- Back-to-back accesses are allowed every cycle. At most one outstanding read per requester.
- When valid is low, rdata outputs are 0.

## Timing
- **Reset:** every output is 0. buf_valid, starve_cnt, rd_if and rd_ls are 0.
- **Reset asserted while a read is outstanding:** the response is dropped; no valid pulse in the following cycle.
- if_ready, ls_ready and the mem_* outputs are combinational from the requests and current state in cycle N.
- if_valid and ls_valid are registered and assert in exactly N+1.
- **Read latency:** one cycle from ready to valid, for both hit and miss.
- **Requester contract:** a requester holds req, addr, we and wdata stable until ready. Dropping req before ready cancels the request with no side effect.
- **Simultaneous if miss and ls, starve_cnt<STARVE_LIMIT:** ls wins.
- **Simultaneous if hit and ls:** both are ready in the same cycle, unless it is the same-word write case.
- **ls write followed by fetch of the same word the next cycle:** a miss, which returns the new data.

## Test plan
- **ls write then fetch.** ls write 0x67452301 @0x08000010, then a fetch miss @0x08000010.
  - mem_write_enable=1 for one cycle.
  - The fetch drives mem_address=0x08000010.
  - if_valid the next cycle with if_rdata=0x67452301.
- **Buffer hit.** After the above, fetch @0x08000012.
  - if_ready in the same cycle with mem_write_enable=0 and mem_address=0.
  - if_valid the next cycle with 0x67452301.
- **Same-word write invalidates the buffer.** Buffer holds 0x08000010; ls write 0xDDCCBBAA @0x08000010 concurrent with a fetch @0x08000012.
  - Fetch is refused in that cycle and misses in the next.
  - if_rdata=0xDDCCBBAA.
- **Starvation guard.** ls_req held high with reads, if_req high with a miss @0x08000014, STARVE_LIMIT=4.
  - ls granted 4 cycles.
  - 5th cycle: if_ready=1, ls_ready=0, mem_address=0x08000014.
  - starve_cnt back to 0.
- **Misaligned ls address.** ls read @0x08000013.
  - mem_address=0x08000010.
  - ls_valid the next cycle with the stored word. No if_valid pulse.
- **Reset mid-read.** Fetch miss granted in N, reset high in N+1.
  - if_valid stays 0.
  - buf_valid=0.
  - All outputs 0 while reset is high.
